// File: rtl/gun_port_pkg.sv
// ============================================================================
//  Module      : gun_port_pkg
//  Description : Shared lightgun peripheral definitions: latch state machine
//                encoding and Saturn peripheral-port bit positions.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package gun_port_pkg;

   // Frame-latch state machine: wait for frame, armed for one hit, hit taken
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_HOLD  = 2'd2
   } gun_state_t;

   // Peripheral-port pin positions (pins are active-low)
   localparam int c_PD_C     = 3;
   localparam int c_PD_A     = 4;
   localparam int c_PD_B     = 5;
   localparam int c_PD_START = 6;

   // Device ID pattern presented on the low three pins
   localparam logic [2:0] c_PD_ID = 3'b111;

   // Build the active-low port image from active-high button levels
   function automatic logic [6:0] f_port_image(input logic a, input logic b,
                                               input logic c, input logic start);
      logic [6:0] v;
      v             = {4'hF, c_PD_ID};
      v[c_PD_A]     = ~a;
      v[c_PD_B]     = ~b;
      v[c_PD_C]     = ~c;
      v[c_PD_START] = ~start;
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gun_port_if.sv
// ============================================================================
//  Module      : gun_port_if
//  Description : Signal bundle between the lightgun port block and its
//                surroundings (gun, VDP2 timing/latch, CPU flag access).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface gun_port_if;
   // Gun side
   logic       SENSOR;
   logic       BTN_A;
   logic       BTN_B;
   logic       BTN_C;
   logic       BTN_START;
   // VDP2 timing and register side
   logic       VDE;
   logic [9:0] HCNT;
   logic [8:0] VCNT;
   logic       EXLTEN;
   // CPU side
   logic       FLAG_CLR;
   // Results
   logic [6:0] PORT_DATA;
   logic       EXLT;
   logic [9:0] LAT_H;
   logic [8:0] LAT_V;
   logic       EXLTFG;

   // Environment driving the block
   modport master (
      output SENSOR, BTN_A, BTN_B, BTN_C, BTN_START,
      output VDE, HCNT, VCNT, EXLTEN, FLAG_CLR,
      input  PORT_DATA, EXLT, LAT_H, LAT_V, EXLTFG
   );

   // The lightgun port block itself
   modport slave (
      input  SENSOR, BTN_A, BTN_B, BTN_C, BTN_START,
      input  VDE, HCNT, VCNT, EXLTEN, FLAG_CLR,
      output PORT_DATA, EXLT, LAT_H, LAT_V, EXLTFG
   );
endinterface

`default_nettype wire

// File: rtl/gun_port_sync.sv
// ============================================================================
//  Module      : gun_sync
//  Description : N-flop synchronizer for one asynchronous level input,
//                cleared to 0 by the asynchronous active-low reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gun_sync #(
   parameter int N = 2
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_d,
   output logic      o_q
);

   logic [N-1:0] r_sync;

   // Shift the raw level through the flop chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[N-2:0], i_d};
      end
   end

   assign o_q = r_sync[N-1];

endmodule

`default_nettype wire

// File: rtl/gun_port.sv
// ============================================================================
//  Module      : gun_port
//  Description : Saturn lightgun peripheral port. Synchronizes sensor and
//                buttons, drives the active-low port pins and captures the
//                VDP2 beam position on the first enabled sensor edge of each
//                frame, with an EXLT pulse and a CPU-clearable flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gun_port
   import gun_port_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int EXLT_W      = 4
) (
   input  wire logic CLK,
   input  wire logic RESET_N,
   gun_port_if.slave bus
);

   // Synchronizer lane assignment
   localparam int c_LANE_SENSOR = 0;
   localparam int c_LANE_A      = 1;
   localparam int c_LANE_B      = 2;
   localparam int c_LANE_C      = 3;
   localparam int c_LANE_START  = 4;
   localparam int c_LANES       = 5;

   // Pulse counter holds remaining cycles after the first high cycle
   localparam logic [3:0] c_EXLT_RELOAD = 4'(EXLT_W - 1);

   logic [c_LANES-1:0] w_raw;
   logic [c_LANES-1:0] w_synced;

   gun_state_t         r_state;
   logic               r_vde;
   logic               r_sensor;
   logic               r_exlt;
   logic [3:0]         r_exlt_cnt;
   logic [9:0]         r_lat_h;
   logic [8:0]         r_lat_v;
   logic               r_exltfg;
   logic [6:0]         r_port_data;

   logic               w_sensor_s;
   logic               w_vde_rise;
   logic               w_vde_fall;
   logic               w_hit;

   assign w_raw[c_LANE_SENSOR] = bus.SENSOR;
   assign w_raw[c_LANE_A]      = bus.BTN_A;
   assign w_raw[c_LANE_B]      = bus.BTN_B;
   assign w_raw[c_LANE_C]      = bus.BTN_C;
   assign w_raw[c_LANE_START]  = bus.BTN_START;

   generate
      for (genvar gi = 0; gi < c_LANES; gi++) begin : g_sync
         gun_sync #(
            .N (SYNC_STAGES)
         ) u_sync (
            .clk   (CLK),
            .rst_n (RESET_N),
            .i_d   (w_raw[gi]),
            .o_q   (w_synced[gi])
         );
      end
   endgenerate

   assign w_sensor_s = w_synced[c_LANE_SENSOR];
   assign w_vde_rise =  bus.VDE & ~r_vde;
   assign w_vde_fall = ~bus.VDE &  r_vde;
   // Only the first enabled sensor rising edge of an armed frame counts
   assign w_hit      = (r_state == ST_ARMED) & bus.EXLTEN & w_sensor_s & ~r_sensor;

   // Register the port pin image from the synchronized buttons
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_port_data <= 7'h7F;
      end else begin
         r_port_data <= f_port_image(w_synced[c_LANE_A], w_synced[c_LANE_B],
                                     w_synced[c_LANE_C], w_synced[c_LANE_START]);
      end
   end

   // Frame state machine with position latch, flag and EXLT pulse generator
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= ST_IDLE;
         r_vde      <= 1'b0;
         r_sensor   <= 1'b0;
         r_exlt     <= 1'b0;
         r_exlt_cnt <= 4'd0;
         r_lat_h    <= 10'd0;
         r_lat_v    <= 9'd0;
         r_exltfg   <= 1'b0;
      end else begin
         r_vde    <= bus.VDE;
         r_sensor <= w_sensor_s;

         case (r_state)
            ST_IDLE: begin
               if (w_vde_rise) begin
                  r_state <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               // A hit coinciding with end of frame is still taken
               if (w_hit) begin
                  r_state <= w_vde_fall ? ST_IDLE : ST_HOLD;
               end else if (w_vde_fall) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (w_vde_fall) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // Set has priority over the CPU clear strobe
         if (w_hit) begin
            r_lat_h  <= bus.HCNT;
            r_lat_v  <= bus.VCNT;
            r_exltfg <= 1'b1;
         end else if (bus.FLAG_CLR) begin
            r_exltfg <= 1'b0;
         end

         // Pulse starts the cycle after the hit and lasts EXLT_W cycles
         if (w_hit) begin
            r_exlt     <= 1'b1;
            r_exlt_cnt <= c_EXLT_RELOAD;
         end else if (r_exlt_cnt != 4'd0) begin
            r_exlt_cnt <= r_exlt_cnt - 4'd1;
         end else begin
            r_exlt     <= 1'b0;
         end
      end
   end

   assign bus.PORT_DATA = r_port_data;
   assign bus.EXLT      = r_exlt;
   assign bus.LAT_H     = r_lat_h;
   assign bus.LAT_V     = r_lat_v;
   assign bus.EXLTFG    = r_exltfg;

endmodule

`default_nettype wire

// File: tb/tb_gun_port.sv
// ============================================================================
//  Module      : tb_gun_port
//  Description : Self-checking bench for gun_port: directed button table,
//                hand-written latch sequences and random frames compared
//                against a behavioural frame/latch model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gun_port;

   localparam int N = 2;
   localparam int W = 4;

   logic CLK     = 1'b0;
   logic RESET_N = 1'b0;

   gun_port_if bus();

   gun_port #(
      .SYNC_STAGES (N),
      .EXLT_W      (W)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;

   // Behavioural model: input history, frame bookkeeping, pulse length left
   bit [5:0]   h_sen, h_a, h_b, h_c, h_st;
   bit         m_prev_vde;
   int         m_mode;      // 0 waiting for frame, 1 frame open, 2 frame used
   int         m_left;
   logic [9:0] m_lh;
   logic [8:0] m_lv;
   bit         m_fg;

   typedef struct {
      logic       a, b, c, st;
      logic [6:0] exp;
   } btn_vec_t;

   btn_vec_t tv[5];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      h_sen = '0; h_a = '0; h_b = '0; h_c = '0; h_st = '0;
      m_prev_vde = 1'b0;
      m_mode = 0;
      m_left = 0;
      m_lh = '0;
      m_lv = '0;
      m_fg = 1'b0;
   endtask

   task automatic model_step();
      bit s, sp, rise, fall, hit;
      h_sen = {h_sen[4:0], bus.SENSOR};
      h_a   = {h_a[4:0],   bus.BTN_A};
      h_b   = {h_b[4:0],   bus.BTN_B};
      h_c   = {h_c[4:0],   bus.BTN_C};
      h_st  = {h_st[4:0],  bus.BTN_START};
      s    = h_sen[N];
      sp   = h_sen[N+1];
      rise = bus.VDE && !m_prev_vde;
      fall = !bus.VDE && m_prev_vde;
      hit  = (m_mode == 1) && bus.EXLTEN && s && !sp;
      if (hit) begin
         m_lh   = bus.HCNT;
         m_lv   = bus.VCNT;
         m_fg   = 1'b1;
         m_left = W;
      end else begin
         if (bus.FLAG_CLR) m_fg = 1'b0;
         if (m_left > 0) m_left--;
      end
      case (m_mode)
         0: if (rise) m_mode = 1;
         1: if (hit) m_mode = fall ? 0 : 2; else if (fall) m_mode = 0;
         default: if (fall) m_mode = 0;
      endcase
      m_prev_vde = bus.VDE;
   endtask

   function automatic logic [27:0] model_out();
      return {~h_st[N], ~h_b[N], ~h_a[N], ~h_c[N], 3'b111,
              (m_left > 0), m_lh, m_lv, m_fg};
   endfunction

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
      check("model", 32'({bus.PORT_DATA, bus.EXLT, bus.LAT_H, bus.LAT_V, bus.EXLTFG}),
            32'(model_out()));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic count_exlt(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.EXLT) cnt++;
      end
   endtask

   initial begin
      int cnt;
      logic [6:0] prev_port;

      bus.SENSOR = 0; bus.BTN_A = 0; bus.BTN_B = 0; bus.BTN_C = 0; bus.BTN_START = 0;
      bus.VDE = 0; bus.HCNT = '0; bus.VCNT = '0; bus.EXLTEN = 0; bus.FLAG_CLR = 0;
      model_reset();

      tv[0] = '{a:1, b:0, c:0, st:1, exp:7'b0101111};
      tv[1] = '{a:0, b:0, c:0, st:0, exp:7'b1111111};
      tv[2] = '{a:0, b:1, c:0, st:0, exp:7'b1011111};
      tv[3] = '{a:0, b:0, c:1, st:0, exp:7'b1110111};
      tv[4] = '{a:1, b:1, c:1, st:1, exp:7'b0000111};

      #12;
      check("reset_state", 32'({bus.PORT_DATA, bus.EXLT, bus.LAT_H, bus.LAT_V, bus.EXLTFG}),
            32'({7'h7F, 1'b0, 10'd0, 9'd0, 1'b0}));
      @(negedge CLK);
      RESET_N = 1'b1;

      // Button table: unchanged after N cycles, new image after N+1
      prev_port = 7'h7F;
      for (int i = 0; i < 5; i++) begin
         bus.BTN_A = tv[i].a; bus.BTN_B = tv[i].b; bus.BTN_C = tv[i].c; bus.BTN_START = tv[i].st;
         ticks(N);
         check("btn_latency", 32'(bus.PORT_DATA), 32'(prev_port));
         tick();
         check("btn_image", 32'(bus.PORT_DATA), 32'(tv[i].exp));
         prev_port = tv[i].exp;
      end
      bus.BTN_A = 0; bus.BTN_B = 0; bus.BTN_C = 0; bus.BTN_START = 0;
      ticks(N + 2);

      // Basic hit
      bus.EXLTEN = 1; bus.HCNT = 10'd150; bus.VCNT = 9'd100; bus.VDE = 1;
      ticks(2);
      bus.SENSOR = 1;
      ticks(N);
      tick();
      check("hit_flag", 32'(bus.EXLTFG), 32'd1);
      check("hit_lat_h", 32'(bus.LAT_H), 32'd150);
      check("hit_lat_v", 32'(bus.LAT_V), 32'd100);
      check("hit_exlt_start", 32'(bus.EXLT), 32'd1);
      count_exlt(10, cnt);
      check("exlt_width", 32'(cnt + 1), 32'(W));

      // Second edge in the same frame is ignored
      bus.SENSOR = 0;
      ticks(3);
      bus.HCNT = 10'd200; bus.SENSOR = 1;
      count_exlt(8, cnt);
      check("double_exlt", 32'(cnt), 32'd0);
      check("double_lat_h", 32'(bus.LAT_H), 32'd150);
      bus.VDE = 0; bus.SENSOR = 0;
      ticks(3);
      bus.FLAG_CLR = 1; tick(); bus.FLAG_CLR = 0;
      check("clr_alone_a", 32'(bus.EXLTFG), 32'd0);

      // Clear strobe colliding with a hit: set wins
      bus.VDE = 1; ticks(2);
      bus.SENSOR = 1; bus.HCNT = 10'd300;
      ticks(N);
      bus.FLAG_CLR = 1; tick(); bus.FLAG_CLR = 0;
      check("clr_collision", 32'(bus.EXLTFG), 32'd1);
      check("clr_collision_lat", 32'(bus.LAT_H), 32'd300);
      ticks(6);
      bus.FLAG_CLR = 1; tick(); bus.FLAG_CLR = 0;
      check("clr_alone_b", 32'(bus.EXLTFG), 32'd0);
      check("clr_keeps_lat", 32'(bus.LAT_H), 32'd300);
      bus.VDE = 0; bus.SENSOR = 0;
      ticks(4);

      // Latch disabled
      bus.EXLTEN = 0; bus.VDE = 1; ticks(2);
      bus.SENSOR = 1; bus.HCNT = 10'd400;
      count_exlt(8, cnt);
      check("dis_exlt", 32'(cnt), 32'd0);
      check("dis_lat_h", 32'(bus.LAT_H), 32'd300);
      check("dis_flag", 32'(bus.EXLTFG), 32'd0);
      bus.SENSOR = 0; bus.EXLTEN = 1; bus.VDE = 0;
      ticks(3);

      // Sensor already high when the frame opens
      bus.SENSOR = 1; ticks(4);
      bus.VDE = 1; ticks(6);
      check("preheld_flag", 32'(bus.EXLTFG), 32'd0);
      bus.VDE = 0; bus.SENSOR = 0;
      ticks(3);

      // Hit on the same cycle as the frame end
      bus.VDE = 1; ticks(2);
      bus.SENSOR = 1; bus.HCNT = 10'd500; bus.VCNT = 9'd7;
      ticks(N);
      bus.VDE = 0; tick();
      check("edge_end_lat_h", 32'(bus.LAT_H), 32'd500);
      check("edge_end_lat_v", 32'(bus.LAT_V), 32'd7);
      check("edge_end_flag", 32'(bus.EXLTFG), 32'd1);
      bus.SENSOR = 0; bus.FLAG_CLR = 1; tick(); bus.FLAG_CLR = 0;
      ticks(W + 2);

      // Reset in the middle of an EXLT pulse
      bus.VDE = 1; ticks(2);
      bus.SENSOR = 1; bus.HCNT = 10'd600;
      ticks(N);
      tick();
      tick();
      check("pre_reset_exlt", 32'(bus.EXLT), 32'd1);
      #2;
      RESET_N = 1'b0;
      model_reset();
      #1;
      check("reset_exlt", 32'(bus.EXLT), 32'd0);
      check("reset_mid", 32'({bus.PORT_DATA, bus.EXLT, bus.LAT_H, bus.LAT_V, bus.EXLTFG}),
            32'({7'h7F, 1'b0, 10'd0, 9'd0, 1'b0}));
      bus.VDE = 0;
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.SENSOR = ~bus.SENSOR;
         ticks(3);
      end
      check("post_reset_flag", 32'(bus.EXLTFG), 32'd0);
      check("post_reset_lat_h", 32'(bus.LAT_H), 32'd0);
      bus.SENSOR = 0;
      ticks(3);

      // Random frames against the model
      for (int f = 0; f < 40; f++) begin
         bus.VDE = 0;
         for (int i = 0; i < int'($urandom_range(3, 8)); i++) begin
            if ($urandom_range(0, 3) == 0) bus.SENSOR = ~bus.SENSOR;
            bus.FLAG_CLR = ($urandom_range(0, 9) == 0);
            tick();
         end
         bus.VDE = 1;
         for (int i = 0; i < int'($urandom_range(10, 40)); i++) begin
            if ($urandom_range(0, 3) == 0) bus.SENSOR = ~bus.SENSOR;
            bus.EXLTEN   = ($urandom_range(0, 4) != 0);
            bus.FLAG_CLR = ($urandom_range(0, 9) == 0);
            bus.HCNT     = 10'($urandom);
            bus.VCNT     = 9'($urandom);
            if ($urandom_range(0, 7) == 0) begin
               bus.BTN_A     = 1'($urandom);
               bus.BTN_B     = 1'($urandom);
               bus.BTN_C     = 1'($urandom);
               bus.BTN_START = 1'($urandom);
            end
            tick();
         end
      end
      bus.FLAG_CLR = 0;
      ticks(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gun_port.md
GUN_PORT -- requirements
Module: gun_port

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on SENSOR and button inputs (legal 2..4).
REQ-002 Parameter EXLT_W, default 4: EXLT pulse width in CLK cycles (legal 1..15).
REQ-003 CLK  in  1  system clock; the single clock of the block.
REQ-004 RESET_N  in  1  reset, asynchronous and active-low.
REQ-005 SENSOR  in  1  lightgun photo-sensor, active-high, asynchronous to the latch logic.
REQ-006 BTN_A, BTN_B, BTN_C, BTN_START  in  1 each  lightgun buttons, active-high.
REQ-007 VDE  in  1  vertical display enable from VDP2 timing.
REQ-008 HCNT  in  10  current VDP2 horizontal pixel counter.
REQ-009 VCNT  in  9  current VDP2 line counter.
REQ-010 EXLTEN  in  1  external-latch enable, VDP2 register bit.
REQ-011 FLAG_CLR  in  1  one-cycle strobe for CPU read of the flag register.
REQ-012 PORT_DATA  out  7  Saturn peripheral-port pins, active-low.
REQ-013 EXLT  out  1  external latch pulse to VDP2.
REQ-014 LAT_H  out  10  latched horizontal count.
REQ-015 LAT_V  out  9  latched vertical count.
REQ-016 EXLTFG  out  1  latch-occurred flag.

Function
REQ-017 SENSOR and each button pass through SYNC_STAGES flops; all logic uses the synchronized copies.
REQ-018 PORT_DATA[4]=~A_s, [5]=~B_s, [6]=~START_s, [3]=~C_s, [2:0]=3'b111 (ID bits); the outputs are registered, so latency is SYNC_STAGES+1 cycles.
REQ-019 The state machine has three states: IDLE, ARMED, HOLD. Reset state is IDLE.
REQ-020 IDLE->ARMED on the VDE rising edge (registered VDE compare).
REQ-021 ARMED->HOLD on a qualified hit, defined as a synced SENSOR rising edge while EXLTEN=1.
REQ-022 HOLD->IDLE on the VDE falling edge; ARMED->IDLE on the VDE falling edge with no hit.
REQ-023 At most one latch occurs per frame; further SENSOR edges in HOLD or IDLE are ignored.
REQ-024 On a qualified hit, LAT_H<=HCNT and LAT_V<=VCNT in the same cycle the edge is detected; EXLTFG<=1.
REQ-025 On a qualified hit, EXLT goes high the next cycle for exactly EXLT_W cycles, using a 4-bit down-counter.
REQ-026 FLAG_CLR clears EXLTFG; if FLAG_CLR and a qualified hit occur in the same cycle, set wins and EXLTFG stays 1.
REQ-027 LAT_H and LAT_V hold their values until the next qualified hit; FLAG_CLR does not alter them.
REQ-028 If EXLTEN falls while in ARMED, the state is unchanged and hits are merely disqualified; an EXLT pulse already in progress completes.
REQ-029 If a VDE falling edge and a qualified hit occur in the same cycle, the latch is taken and the next state is IDLE.
REQ-030 If SENSOR is already high at the IDLE->ARMED transition, no hit is taken; a fresh rising edge is required.

Reset
REQ-031 RESET_N low asynchronously forces: state IDLE, all synchronizer flops 0, PORT_DATA=7'h7F, EXLT=0, EXLT counter 0, LAT_H=0, LAT_V=0, EXLTFG=0, registered VDE=0, registered SENSOR=0.
REQ-032 Reset asserted mid-pulse truncates EXLT immediately; after reset deasserts, the block waits for a VDE rising edge before it arms.

Structure
REQ-033 The state enum (IDLE/ARMED/HOLD) and the PORT_DATA bit-index constants belong in the shared saturn peripheral package.
REQ-034 One sub-module, gun_sync (parameterized N-flop synchronizer with asynchronous active-low reset), is instantiated per synchronized input.
REQ-035 There are no other sub-modules, no memories, and no combinational output paths.

Verification
REQ-036 Hit: VDE rises, SENSOR rises with HCNT=10'd150, VCNT=9'd100, EXLTEN=1 -> LAT_H=150, LAT_V=100, EXLTFG=1, EXLT high for 4 cycles.
REQ-037 Double hit: a second SENSOR edge in the same frame at HCNT=200 -> LAT_H stays 150, no second EXLT pulse.
REQ-038 Clear collision: FLAG_CLR asserted in the same cycle as a qualified hit -> EXLTFG=1; FLAG_CLR alone on a later cycle -> EXLTFG=0.
REQ-039 Disabled: EXLTEN=0 with a SENSOR edge -> EXLT stays 0, LAT_H/LAT_V unchanged, EXLTFG=0.
REQ-040 Buttons: BTN_A=1, BTN_START=1 -> PORT_DATA=7'b0101111 after SYNC_STAGES+1 cycles.
REQ-041 Reset: RESET_N pulsed low during cycle 2 of an EXLT pulse -> EXLT=0 immediately; with SENSOR edges continuing and no VDE rise, no latch occurs.
